// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready imem port and presents
// {instruction, stall_b} to the decode controller. Optional counter under IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'h3f
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        stall_b,
  input  logic        decode_hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // Handshakes: a request transfers on a cycle where imem_req_valid & imem_req_ready;
  // valid and address stay put until then unless a redirect moves the PC. Each accepted
  // request gets exactly one imem_rsp_valid pulse at least one cycle later. The presented
  // instruction is consumed on a cycle where stall_b & ~decode_hold.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        stall_b_q, stall_b_d;
  logic        halted_q, halted_d;

  logic consume;
  logic req_valid;
  logic req_fire;
  logic req_outstanding;

  assign consume   = stall_b_q & ~decode_hold;
  // Only one instruction can be buffered, so request only when the slot is free or draining now.
  assign req_valid = (state_q == ST_FETCH) & (~stall_b_q | ~decode_hold);
  assign req_fire  = req_valid & imem_req_ready;

  // A response is still owed if we are waiting on one that has not arrived, or one is accepted now.
  assign req_outstanding = (((state_q == ST_WAIT) | (state_q == ST_DRAIN)) & ~imem_rsp_valid)
                         | req_fire;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    stall_b_d = stall_b_q;
    halted_d  = halted_q;

    if (consume) begin
      stall_b_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d   = imem_rsp_data;
          pc_out_d  = pc_q;
          stall_b_d = 1'b1;
          pc_d      = pc_q + 32'd4;
          if (imem_rsp_data[31:26] == HALT_OP) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect overrides everything: the presented instruction is flushed and any
    // response still owed is swallowed in DRAIN so it cannot land at the new target.
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~32'h0000_0003;
      instr_d   = instr_q;
      pc_out_d  = pc_out_q;
      stall_b_d = 1'b0;
      halted_d  = 1'b0;
      state_d   = req_outstanding ? ST_DRAIN : ST_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      pc_out_q  <= 32'h0;
      stall_b_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      stall_b_q <= stall_b_d;
      halted_q  <= halted_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // A consume on a redirect cycle counts: the controller took the branch itself.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (consume) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'h0;
`endif

  assign imem_req_valid = req_valid;
  assign imem_addr      = pc_q;
  assign instruction    = instr_q;
  assign pc_out         = pc_out_q;
  assign stall_b        = stall_b_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: imem responder, delivery scoreboard, wrap instance.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        stall_b;
  logic        decode_hold;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic [31:0] w_instruction;
  logic [31:0] w_pc_out;
  logic        w_stall_b;
  logic        w_decode_hold;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_halted;
  logic [31:0] w_fetch_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  instr_fetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .stall_b        (stall_b),
    .decode_hold    (decode_hold),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_addr      (w_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .instruction    (w_instruction),
    .pc_out         (w_pc_out),
    .stall_b        (w_stall_b),
    .decode_hold    (w_decode_hold),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .halted         (w_halted),
    .fetch_count    (w_fetch_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Any address with low nibble C holds a halt word; everything else is an ordinary opcode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a[3:0] == 4'hC) ? 32'hFC00_0000 : (32'h2000_0000 | a);
  endfunction

  function automatic logic [31:0] exp_count(input int n);
`ifdef IFU_PERF_CNT_EN
    return 32'(n);
`else
    return 32'h0 & 32'(n);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---------------- imem responder ----------------
  int          lat = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_wait = 0;

  always @(negedge clk) begin
    if (rst) begin
      imem_rsp_valid = 1'b0;
      pend = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        pend = 1'b1;
        pend_addr = imem_addr;
        pend_wait = lat - 1;
      end
    end
  end

  // Wrap instance: always ready, one-cycle responses, logs its first two request addresses.
  logic        w_pend = 1'b0;
  int          w_n = 0;
  logic [31:0] w_log[2];

  always @(negedge clk) begin
    if (rst) begin
      w_rsp_valid = 1'b0;
      w_pend = 1'b0;
    end else begin
      w_rsp_valid = w_pend;
      w_pend = w_req_valid;
      if (w_req_valid && w_n < 2) begin
        w_log[w_n] = w_addr;
        w_n++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && stall_b && !decode_hold) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_delivery observed pc_out=%08h expected=none", pc_out);
      end
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("deliver_pc", pc_out, e);
        check("deliver_instr", instruction, mem_word(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] target, input logic hold_during);
    drive_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    decode_hold    = hold_during;
    drive_cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_halted_and_drained(input string tag);
    for (int i = 0; i < 300 && !(halted === 1'b1 && exp_q.size() == 0); i++) @(negedge clk);
    check({tag, "_halted"}, {31'h0, halted}, 32'h1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_data = 32'h0;
    decode_hold = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    w_req_ready = 1'b1;
    w_rsp_data = 32'h2000_0000;
    w_decode_hold = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_stall_b", {31'h0, stall_b}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Straight-line fetch 0,4,8 then halt word at 0xC
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    drive_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("first_req_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    check("first_stall_b", {31'h0, stall_b}, 32'h1);
    check("first_pc_out", pc_out, 32'h0);
    check("first_instr", instruction, 32'h2000_0000);
    wait_halted_and_drained("halt_a");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halted_no_req", {31'h0, imem_req_valid}, 32'h0);
      check("halted_flag", {31'h0, halted}, 32'h1);
    end
    check("count_after_a", fetch_count, exp_count(4));
    check("wrap_n_req", 32'(w_n), 32'h2);
    check("wrap_first_addr", w_log[0], 32'hFFFF_FFFC);
    check("wrap_second_addr", w_log[1], 32'h0);

    // Resume from halt at 0x40, hold 0x40 presented for 5 cycles
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h48);
    exp_q.push_back(32'h4C);
    pulse_redirect(32'h40, 1'b1);
    @(negedge clk);
    check("resume_halted_clr", {31'h0, halted}, 32'h0);
    check("resume_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("resume_req_addr", imem_addr, 32'h40);
    for (int i = 0; i < 50 && !(stall_b === 1'b1); i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_stall_b", {31'h0, stall_b}, 32'h1);
      check("hold_pc_out", pc_out, 32'h40);
      check("hold_instr", instruction, mem_word(32'h40));
      check("hold_no_req", {31'h0, imem_req_valid}, 32'h0);
      @(negedge clk);
    end
    drive_cycle();
    decode_hold = 1'b0;
    wait_halted_and_drained("halt_b");

    // Redirect while the request for 0x8 is in flight
    lat = 3;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    pulse_redirect(32'h8, 1'b0);
    for (int i = 0; i < 50 && !(imem_req_valid === 1'b1 && imem_addr === 32'h8); i++) @(negedge clk);
    check("req8_seen", imem_addr, 32'h8);
    pulse_redirect(32'h103, 1'b0);
    @(negedge clk);
    check("drain_no_req", {31'h0, imem_req_valid}, 32'h0);
    for (int i = 0; i < 50 && !(imem_req_valid === 1'b1); i++) begin
      check("drain_stall_b", {31'h0, stall_b}, 32'h0);
      @(negedge clk);
    end
    check("redirect_req_addr", imem_addr, 32'h100);
    wait_halted_and_drained("halt_c");

    // Flush a held instruction by redirect; it must not be counted
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    exp_q.push_back(32'h308);
    exp_q.push_back(32'h30C);
    pulse_redirect(32'h200, 1'b1);
    for (int i = 0; i < 50 && !(stall_b === 1'b1); i++) @(negedge clk);
    check("flush_target_pc", pc_out, 32'h200);
    drive_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    drive_cycle();
    redirect_valid = 1'b0;
    decode_hold    = 1'b0;
    @(negedge clk);
    check("flush_stall_b", {31'h0, stall_b}, 32'h0);
    wait_halted_and_drained("halt_d");
    repeat (3) @(negedge clk);
    check("fetch_count_final", fetch_count, exp_count(16));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
